rr_starve_arbiter: RTL and testbench
====================================

Name: rr_starve_arbiter

Overview:
Parametrised N-port round-robin arbiter with per-port starvation promotion. It is the next-generation replacement for the fixed 4-port ingress arbiter. It samples port requests, picks one winner and issues a one-cycle one-hot grant plus a held port select to the downstream interface. The next arbitration starts only after the downstream side signals completion with int_ready.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..16)
SEL_W, $clog2(NUM_PORTS), width of port select
STARVE_CNT, 500, waiting cycles after which a requesting port is promoted to high priority
CNT_W, 9, starvation counter width; must hold STARVE_CNT

Ports:
clk  in  1  clock
rstN  in  1  asynchronous, active-low reset
req  in  NUM_PORTS  per-port request level
trans_started  in  1  downstream transfer in flight; blocks new sampling
int_valid  in  1  downstream busy; blocks new sampling
int_ready  in  1  downstream done with current grant; releases HOLD
gnt  out  NUM_PORTS  one-hot grant, one-cycle pulse
sel  out  SEL_W  index of the granted port, held until next grant
sel_valid  out  1  high from GRANT through HOLD
hi_pri  out  NUM_PORTS  per-port starvation flag (status)
lock  in  NUM_PORTS  per-port lock request (present only with ARB_LOCK_EN)

Behaviour:
- Reset (async, rstN=0): state=IDLE; gnt=0, sel=0, sel_valid=0, hi_pri=0; all counters 0; rr pointer=NUM_PORTS-1, so port 0 has first priority.
- FSM states: IDLE, SAMPLE, GRANT, HOLD.
- IDLE: if req!=0 and !trans_started and !int_valid, latch req_r<=req and go to SAMPLE. Otherwise stay.
- SAMPLE: form cand = (req_r & hi_pri) if that is nonzero, else req_r. Winner = first set bit of cand searching upward from ptr+1 with wrap modulo NUM_PORTS. Register winner and go to GRANT.
- GRANT: gnt[winner]=1 for exactly this cycle; sel<=winner; sel_valid=1. Go to HOLD.
- HOLD: gnt=0; sel and sel_valid held. On int_ready=1, set ptr<=winner, sel_valid<=0, go to IDLE. If int_ready is already 1 on HOLD entry, HOLD lasts exactly one cycle.
- Latency: request acceptance in IDLE to gnt pulse is 2 clocks. Minimum repeat period is 4 clocks.
- req changes after latching are ignored until the next IDLE sample. A port that drops req before SAMPLE can still win.
- Starvation counter i:
  - cleared on the cycle gnt[i]=1;
  - otherwise increments while req[i]=1, saturating at STARVE_CNT;
  - holds its value while req[i]=0.
- hi_pri[i]=1 when counter i == STARVE_CNT. It clears with the counter on grant.
- Several starved ports: round-robin applies among the starved ports only.
- Width rule: ptr+1 wraps at NUM_PORTS, including non-power-of-two NUM_PORTS; sel never exceeds NUM_PORTS-1.
- Reset asserted mid-operation (any state) aborts immediately. No gnt pulse may follow reset release until a fresh IDLE sample.

Optional Feature:
ARB_LOCK_EN
- Defined: lock port exists. If lock[winner]=1 and req[winner]=1 when HOLD exits, the next SAMPLE bypasses arbitration and selects the same winner; ptr is not advanced. A starved port (hi_pri=1) other than the winner overrides the lock. Starvation counters keep running during lock.
- Undefined: lock port is absent and every arbitration is plain round-robin/starvation.

Decomposition:
- Package arb_pkg: arb_state_t enum (IDLE, SAMPLE, GRANT, HOLD); default constants ARB_DEF_PORTS=4 and ARB_DEF_STARVE=500.
- Sub-module rr_pick: combinational rotating-priority picker (inputs cand and ptr; outputs winner and any), instantiated once in SAMPLE logic.

Test Plan:
- Reset, req=4'b1111, int_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; each gnt 2 clocks after IDLE sample; sel matches.
- req=4'b0101 held, int_ready=1 -> grants alternate port0, port2; ports 1 and 3 never granted.
- int_valid=1 with req=4'b0010 -> no SAMPLE. Deassert int_valid -> gnt=0010 two clocks later.
- STARVE_CNT=8, port 3 requesting, lock/int_ready held so ports 0–2 keep winning -> hi_pri[3]=1 after 8 waiting cycles; next arbitration grants port 3 even though ptr favours port 0; hi_pri[3] clears.
- rstN pulsed low during HOLD with sel=2 -> gnt=0, sel=0, sel_valid=0 immediately. After release with req=0100, first grant is port 2, 2 clocks after sample.
- ARB_LOCK_EN, lock=0001, req=0011 -> port 0 granted repeatedly. Drop lock[0] -> next grant is port 1.

Source files
------------

// File: rtl/rr_starve_arbiter_pkg.sv
// Shared types and default constants for the round-robin starvation arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        GRANT  = 2'd2,
        HOLD   = 2'd3
    } arb_state_t;

    localparam int ARB_DEF_PORTS  = 4;
    localparam int ARB_DEF_STARVE = 500;

endpackage

// File: rtl/rr_starve_arbiter_pick.sv
// Rotating-priority picker: first set bit of cand searching upward from ptr+1,
// wrapping modulo NUM_PORTS (safe for non-power-of-two port counts).
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] cand,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     winner,
    output logic                 any
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(off);
            if (sum >= (SEL_W+1)'(NUM_PORTS)) begin
                sum = sum - (SEL_W+1)'(NUM_PORTS);
            end
            idx = sum[SEL_W-1:0];
            if (!any && cand[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_starve_arbiter.sv
// N-port round-robin arbiter with per-port starvation promotion.
// Optional sticky lock support is compiled in with `define ARB_LOCK_EN.
module rr_starve_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS  = ARB_DEF_PORTS,
    parameter int SEL_W      = $clog2(NUM_PORTS),
    parameter int STARVE_CNT = ARB_DEF_STARVE,
    parameter int CNT_W      = 9
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 trans_started,
    input  logic                 int_valid,
    input  logic                 int_ready,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic [NUM_PORTS-1:0] hi_pri
`ifdef ARB_LOCK_EN
    ,
    input  logic [NUM_PORTS-1:0] lock
`endif
);

    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_CNT);
    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_PORTS - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_PORTS-1:0]   req_r_q, req_r_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [SEL_W-1:0]       win_q, win_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   sel_valid_q, sel_valid_d;

    logic [NUM_PORTS-1:0]   cand_hi;
    logic [NUM_PORTS-1:0]   cand;
    logic [SEL_W-1:0]       pick_win;
    logic                   pick_any;

`ifdef ARB_LOCK_EN
    logic                   lock_hold_q, lock_hold_d;
    logic [NUM_PORTS-1:0]   win_onehot;
    logic                   other_starved;

    always_comb begin
        win_onehot        = '0;
        win_onehot[win_q] = 1'b1;
    end

    // Only a starved port other than the locked owner can break the lock.
    assign other_starved = |(req_r_q & hi_pri & ~win_onehot);
`endif

    // Starved requesters take the whole round when any are present.
    assign cand_hi = req_r_q & hi_pri;
    assign cand    = (|cand_hi) ? cand_hi : req_r_q;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W)
    ) u_pick (
        .cand   (cand),
        .ptr    (ptr_q),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        req_r_d     = req_r_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = '0;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
`ifdef ARB_LOCK_EN
        lock_hold_d = lock_hold_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && !trans_started && !int_valid) begin
                    req_r_d = req;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                win_d   = pick_win;
                state_d = pick_any ? GRANT : IDLE;
`ifdef ARB_LOCK_EN
                if (lock_hold_q && !other_starved) begin
                    win_d   = win_q;
                    state_d = GRANT;
                end
                lock_hold_d = 1'b0;
`endif
                if (state_d == GRANT) begin
                    gnt_d[win_d] = 1'b1;
                    sel_d        = win_d;
                    sel_valid_d  = 1'b1;
                end
            end
            GRANT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (int_ready) begin
                    ptr_d       = win_q;
                    sel_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef ARB_LOCK_EN
                    lock_hold_d = lock[win_q] && req[win_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            req_r_q     <= '0;
            ptr_q       <= PTR_RST;
            win_q       <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_r_q     <= req_r_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
`ifdef ARB_LOCK_EN
            lock_hold_q <= lock_hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;

    // Per-port wait counters; the flag is registered from the next count so
    // it tracks the counter on the same cycle.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             hi_q;

        always_comb begin
            cnt_d = cnt_q;
            if (gnt_q[gi]) begin
                cnt_d = '0;
            end else if (req[gi] && (cnt_q != STARVE_C)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                cnt_q <= '0;
                hi_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                hi_q  <= (cnt_d == STARVE_C);
            end
        end

        assign hi_pri[gi] = hi_q;
    end

endmodule

// File: tb/tb_rr_starve_arbiter.sv
// Self-checking bench for rr_starve_arbiter (5 ports, STARVE_CNT=8): vector
// table, hand-written corner sequences and a randomized run against a model.
module tb_rr_starve_arbiter;

    localparam int NP = 5;
    localparam int SW = 3;
    localparam int SC = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic [NP-1:0] req;
    logic          trans_started;
    logic          int_valid;
    logic          int_ready;
    logic [NP-1:0] gnt;
    logic [SW-1:0] sel;
    logic          sel_valid;
    logic [NP-1:0] hi_pri;
`ifdef ARB_LOCK_EN
    logic [NP-1:0] lock;
`endif

    rr_starve_arbiter #(
        .NUM_PORTS  (NP),
        .SEL_W      (SW),
        .STARVE_CNT (SC),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .req           (req),
        .trans_started (trans_started),
        .int_valid     (int_valid),
        .int_ready     (int_ready),
        .gnt           (gnt),
        .sel           (sel),
        .sel_valid     (sel_valid),
        .hi_pri        (hi_pri)
`ifdef ARB_LOCK_EN
        ,
        .lock          (lock)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit            rst_first;
        logic [NP-1:0] req;
        logic [NP-1:0] exp_gnt;
        logic [SW-1:0] exp_sel;
        logic          exp_sv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN          = 1'b0;
        req           = '0;
        trans_started = 1'b0;
        int_valid     = 1'b0;
        int_ready     = 1'b0;
`ifdef ARB_LOCK_EN
        lock          = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.sel", 32'(sel), 32'h0);
        chk("rst.sv", 32'(sel_valid), 32'h0);
        chk("rst.hi", 32'(hi_pri), 32'h0);
        rstN = 1'b1;
    endtask

    // One grant every four cycles: SAMPLE, GRANT, HOLD, IDLE.
    task automatic add_block(input logic [NP-1:0] r, input int ord[$]);
        vec_t v;
        int   prev;
        prev = 0;
        for (int g = 0; g < ord.size(); g++) begin
            for (int ph = 0; ph < 4; ph++) begin
                v.rst_first = (g == 0 && ph == 0);
                v.req       = r;
                v.exp_gnt   = (ph == 1) ? NP'(1 << ord[g]) : '0;
                v.exp_sel   = (ph == 0) ? SW'(prev) : SW'(ord[g]);
                v.exp_sv    = (ph == 1 || ph == 2);
                vecs.push_back(v);
            end
            prev = ord[g];
        end
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt != '0) begin
                for (int i = 0; i < NP; i++) if (gnt[i]) idx = i;
                return;
            end
        end
    endtask

    // Reference model state.
    int            m_ph;
    int            m_cnt[NP];
    int            m_ptr;
    int            m_win;
    int            m_sel;
    logic [NP-1:0] m_reqr;

    task automatic model_reset();
        m_ph  = 0;
        m_ptr = NP - 1;
        m_win = 0;
        m_sel = 0;
        m_reqr = '0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [NP-1:0] r, input logic ts, input logic iv, input logic ir);
        logic [NP-1:0] starved, pool;
        int            gport;
        bit            found;
        gport = (m_ph == 2) ? m_win : -1;
        starved = '0;
        for (int i = 0; i < NP; i++) starved[i] = (m_cnt[i] == SC);
        case (m_ph)
            0: if (r != 0 && !ts && !iv) begin m_reqr = r; m_ph = 1; end
            1: begin
                pool  = ((m_reqr & starved) != 0) ? (m_reqr & starved) : m_reqr;
                found = 0;
                for (int off = 1; off <= NP; off++) begin
                    if (!found && pool[(m_ptr + off) % NP]) begin
                        m_win = (m_ptr + off) % NP;
                        found = 1;
                    end
                end
                m_sel = m_win;
                m_ph  = 2;
            end
            2: m_ph = 3;
            default: if (ir) begin m_ptr = m_win; m_ph = 0; end
        endcase
        for (int i = 0; i < NP; i++) begin
            if (i == gport) m_cnt[i] = 0;
            else if (r[i]) m_cnt[i] = (m_cnt[i] + 1 > SC) ? SC : m_cnt[i] + 1;
        end
    endtask

    initial begin
        int            q1[$];
        int            q2[$];
        int            got;
        bit            seen;
        logic [NP-1:0] exp_hi;
        logic [NP-1:0] r;
        logic          ts, iv, ir;

        q1 = '{0, 1, 2, 3, 0};
        q2 = '{0, 2, 0, 2};
        add_block(5'b01111, q1);
        add_block(5'b00101, q2);

        // Table-driven rotation checks.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) begin
                do_reset();
                int_ready = 1'b1;
            end
            req = vecs[i].req;
            tick();
            chk($sformatf("tbl%0d.gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("tbl%0d.sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            chk($sformatf("tbl%0d.sv", i), 32'(sel_valid), 32'(vecs[i].exp_sv));
        end

        // int_valid blocks sampling; release gives a grant two clocks later.
        do_reset();
        int_ready = 1'b1;
        req       = 5'b00010;
        int_valid = 1'b1;
        seen      = 0;
        repeat (5) begin
            tick();
            if (gnt != '0 || sel_valid) seen = 1;
        end
        chk("iv.blocked", 32'(seen), 32'h0);
        int_valid = 1'b0;
        tick();
        chk("iv.sample", 32'(gnt), 32'h0);
        tick();
        chk("iv.gnt", 32'(gnt), 32'h02);
        chk("iv.sel", 32'(sel), 32'h1);

        // Starvation: port 3 waits through a long HOLD, then beats port 1.
        do_reset();
        req       = 5'b00001;
        int_ready = 1'b0;
        tick();
        tick();
        chk("st.first", 32'(gnt), 32'h01);
        req = 5'b01000;
        repeat (7) tick();
        chk("st.pre", 32'(hi_pri), 32'h0);
        tick();
        chk("st.hi", 32'(hi_pri), 32'h08);
        tick();
        req       = 5'b01010;
        int_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("st.gnt", 32'(gnt), 32'h08);
        chk("st.sel", 32'(sel), 32'h3);
        tick();
        chk("st.clr", 32'(hi_pri[3]), 32'h0);

        // Reset during HOLD aborts at once; next grant needs a fresh sample.
        do_reset();
        req       = 5'b00100;
        int_ready = 1'b0;
        repeat (3) tick();
        chk("rh.sel", 32'(sel), 32'h2);
        chk("rh.sv", 32'(sel_valid), 32'h1);
        rstN = 1'b0;
        #1;
        chk("rh.async.sel", 32'(sel), 32'h0);
        chk("rh.async.sv", 32'(sel_valid), 32'h0);
        chk("rh.async.gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        rstN      = 1'b1;
        int_ready = 1'b1;
        tick();
        chk("rh.sample", 32'(gnt), 32'h0);
        tick();
        chk("rh.gnt", 32'(gnt), 32'h04);
        chk("rh.gsel", 32'(sel), 32'h2);

`ifdef ARB_LOCK_EN
        do_reset();
        int_ready = 1'b1;
        lock      = 5'b00001;
        req       = 5'b00011;
        for (int k = 0; k < 3; k++) begin
            wait_grant(got);
            chk($sformatf("lk.hold%0d", k), 32'(got), 32'd0);
        end
        lock = '0;
        wait_grant(got);
        chk("lk.release", 32'(got), 32'd1);
`endif

        // Randomized run against the behavioural model.
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            r  = NP'($urandom_range(0, (1 << NP) - 1));
            if ($urandom_range(0, 3) == 0) r = '0;
            ts = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) == 0);
            ir = ($urandom_range(0, 3) == 0);
            req           = r;
            trans_started = ts;
            int_valid     = iv;
            int_ready     = ir;
            model_step(r, ts, iv, ir);
            tick();
            for (int i = 0; i < NP; i++) exp_hi[i] = (m_cnt[i] == SC);
            chk($sformatf("rnd%0d.gnt", c), 32'(gnt), (m_ph == 2) ? 32'(1 << m_win) : 32'h0);
            chk($sformatf("rnd%0d.sel", c), 32'(sel), 32'(m_sel));
            chk($sformatf("rnd%0d.sv", c), 32'(sel_valid), (m_ph >= 2) ? 32'h1 : 32'h0);
            chk($sformatf("rnd%0d.hi", c), 32'(hi_pri), 32'(exp_hi));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
